// File: rtl/bcd_adder_seq.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first,
// with a start/busy/done handshake, ten's-complement subtract and an invalid-digit flag.
module bcd_adder_seq #(
  parameter int DIGITS = 4,
  parameter int IDXW   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  invalid
);

  localparam int W = 4 * DIGITS;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  logic [1:0]      state;
  logic [IDXW-1:0] idx;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            sub_reg;
  logic            carry;

  logic [3:0] a_dig;
  logic [3:0] b_raw;
  logic [3:0] b_dig;
  logic [4:0] t;
  logic [3:0] digit;
  logic       carry_next;
  logic       digit_bad;

  // Operand registers shift right each digit, so the current digit is always in [3:0].
  always_comb begin
    a_dig      = a_reg[3:0];
    b_raw      = b_reg[3:0];
    b_dig      = sub_reg ? (4'd9 - b_raw) : b_raw;
    t          = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry};
    carry_next = (t > 5'd9);
    digit      = carry_next ? (t[3:0] + 4'd6) : t[3:0];
    digit_bad  = (a_dig > 4'd9) || (b_raw > 4'd9);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      sub_reg <= 1'b0;
      carry   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            sub_reg <= sub;
            carry   <= sub ? 1'b1 : cin;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            invalid <= 1'b0;
            state   <= CALC;
          end
        end
        CALC: begin
          sum[4*idx +: 4] <= digit;
          a_reg   <= a_reg >> 4;
          b_reg   <= b_reg >> 4;
          carry   <= carry_next;
          invalid <= invalid | digit_bad;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            cout  <= carry_next;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_adder_seq.sv
// Self-checking bench for bcd_adder_seq: a decimal reference model fills a scoreboard
// queue at each start, and a monitor pops and compares whenever done pulses.
module tb_bcd_adder_seq;

  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;
  localparam int TIMEOUT = 20;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         invalid;
    bit           check_sum;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         invalid;

  exp_t sb_q[$];
  int   vector_count;
  int   miscompare_count;

  bcd_adder_seq #(.DIGITS(DIGITS), .IDXW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .invalid(invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vector_count++;
    if (got !== exp) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int value);
    logic [W-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference model works in plain decimal integers, independent of digit-serial details.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic cv, input logic sv);
    exp_t e;
    int ai, bi, scale, total, modulus;
    bit bad;
    ai = 0; bi = 0; scale = 1; bad = 0; modulus = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) bad = 1;
      ai += int'(av[4*i +: 4]) * scale;
      bi += int'(bv[4*i +: 4]) * scale;
      scale *= 10;
    end
    modulus = scale;
    if (sv) begin
      total = ai - bi;
      e.cout = (total >= 0);
      if (total < 0) total += modulus;
    end else begin
      total = ai + bi + int'(cv);
      e.cout = (total >= modulus);
      total = total % modulus;
    end
    e.sum = to_bcd(total);
    e.invalid = bad;
    e.check_sum = !bad;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        checkOutput("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.check_sum) begin
          checkOutput("sum", 32'(sum), 32'(e.sum));
          checkOutput("cout", 32'(cout), 32'(e.cout));
        end else begin
          checkOutput("cout_known", 32'($isunknown(cout)), 32'd0);
        end
        checkOutput("invalid", 32'(invalid), 32'(e.invalid));
        checkOutput("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic waitDone(output int cycles);
    cycles = 1;
    while (!done && cycles < TIMEOUT) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv, input bit push);
    @(negedge clk);
    a = av; b = bv; cin = cv; sub = sv;
    if (push) sb_q.push_back(model(av, bv, cv, sv));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic cv, input logic sv);
    int cycles;
    launch(av, bv, cv, sv, 1'b1);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    waitDone(cycles);
    checkOutput("latency", 32'(cycles), 32'(DIGITS + 1));
  endtask

  initial begin
    int cycles;
    logic [W-1:0] bad_a;
    vector_count = 0;
    miscompare_count = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    checkOutput("rst_invalid", 32'(invalid), 32'd0);
    rst = 1'b0;

    applyStimulus(to_bcd(1234), to_bcd(8766), 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("sum_held", 32'(sum), 32'(to_bcd(0)));
    checkOutput("cout_held", 32'(cout), 32'd1);

    applyStimulus(to_bcd(9999), to_bcd(0), 1'b1, 1'b0);
    applyStimulus(to_bcd(458), to_bcd(379), 1'b1, 1'b0);
    applyStimulus(to_bcd(5000), to_bcd(1234), 1'b0, 1'b1);
    applyStimulus(to_bcd(1234), to_bcd(5000), 1'b0, 1'b1);
    applyStimulus(to_bcd(4321), to_bcd(4321), 1'b1, 1'b1);

    bad_a = 16'h12A4;
    applyStimulus(bad_a, to_bcd(1), 1'b0, 1'b0);
    applyStimulus(to_bcd(17), to_bcd(25), 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(to_bcd(int'($urandom_range(0, 9999))), to_bcd(int'($urandom_range(0, 9999))),
                    1'($urandom_range(0, 1)), 1'(i % 2));
    end

    // start held through CALC and DONE, operands changed mid-calculation
    @(negedge clk);
    a = to_bcd(2468); b = to_bcd(1357); cin = 1'b0; sub = 1'b0;
    sb_q.push_back(model(to_bcd(2468), to_bcd(1357), 1'b0, 1'b0));
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a = to_bcd(9999); b = to_bcd(9999); cin = 1'b1;
    cycles = 2;
    while (!done && cycles < TIMEOUT) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("hold_latency", 32'(cycles), 32'(DIGITS + 1));
    @(negedge clk);
    checkOutput("hold_done_ignored", 32'(busy), 32'd0);
    start = 1'b0;
    @(negedge clk);
    checkOutput("hold_idle", 32'(busy), 32'd0);
    applyStimulus(to_bcd(100), to_bcd(23), 1'b0, 1'b0);

    // asynchronous reset two cycles into CALC
    launch(to_bcd(8888), to_bcd(1111), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_sum", 32'(sum), 32'd0);
    checkOutput("midrst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (DIGITS + 3) @(negedge clk);
    applyStimulus(to_bcd(6789), to_bcd(1234), 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/bcd_adder_seq.md
Name: bcd_adder_seq

Overview:
- Multi-digit, digit-serial BCD adder/subtractor for the packed-BCD arithmetic path.
- Supersedes the single-digit combinational BCD adder.
- Processes one decimal digit per clock, least significant digit first, behind a start/busy/done handshake.
- Adds subtract mode (ten's complement) and an invalid-digit flag.

Parameters:
- DIGITS, 4, number of BCD digits per operand; legal range 1..16.
- IDXW, 4, digit-index counter width; must satisfy 2^IDXW >= DIGITS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- a  input  4*DIGITS  operand A, packed BCD; digit 0 in bits [3:0].
- b  input  4*DIGITS  operand B, packed BCD.
- cin  input  1  decimal carry-in; used in add mode only.
- sub  input  1  0 = A+B+cin; 1 = A-B.
- busy  output  1  high while a calculation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  4*DIGITS  packed BCD result; held until the next accepted start.
- cout  output  1  decimal carry-out in add mode; 1 = no borrow (A>=B) in subtract mode.
- invalid  output  1  set if any operand digit was >9; held with the result.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, sum=0, cout=0, invalid=0.
  - Index and operand registers cleared.
  - No partial result survives.
- FSM states:
  - IDLE: busy=0. start=1 at an edge latches a, b, sub, and the initial carry, then moves to CALC with idx=0. Initial carry is cin in add mode and 1 in subtract mode. sum, cout and invalid are cleared at the same edge.
  - CALC: busy=1. Each edge processes digit idx and increments idx. At the edge processing digit DIGITS-1, the final carry goes to cout and the state moves to DONE.
  - DONE: done=1 for exactly one cycle, busy=0. Next edge returns to IDLE.
- Latency: start sampled at edge k → digits processed at edges k+1..k+DIGITS → done=1 during the cycle following edge k+DIGITS. Total DIGITS+1 cycles.
- Throughput: a start that is high in DONE is ignored. start is accepted only from IDLE, so minimum spacing is DIGITS+2 cycles.
- start while busy is ignored. Latched operands are unaffected by input changes during CALC.
- Per-digit arithmetic, with bd = b digit (add mode) or 9-bd (subtract mode):
  - t = ad + bd + c, a 5-bit value in 0..19.
  - If t>9: digit = (t+6) mod 16, carry=1. Else digit = t, carry=0.
- Subtract result:
  - A>=B: true difference with cout=1.
  - A<B: ten's complement of (B-A) with cout=0.
- Invalid digits:
  - invalid is set if any digit of a or b (raw, before the 9's complement) is >9.
  - Checked as each digit is processed; sticky until the next start.
  - The calculation still completes. sum is unspecified when invalid=1; cout must still be a defined value.
- Output visibility: sum digits update in place during CALC, but are valid only from the done cycle onward.
- DIGITS=1 degenerates to a 2-cycle single-digit unit. Behaviour is otherwise identical.

Test Plan:
- DIGITS=4, add: a=1234, b=8766, cin=0, start pulse → done exactly 5 cycles after the start edge; sum=0000, cout=1, invalid=0.
- Add with carry chain: a=9999, b=0000, cin=1 → sum=0000, cout=1. Then a=0458, b=0379, cin=1 → sum=0838, cout=0.
- Subtract: a=5000, b=1234, sub=1 → sum=3766, cout=1. Then a=1234, b=5000, sub=1 → sum=6234, cout=0.
- Invalid digit: a=12A4, b=0001, add → done after 5 cycles, invalid=1. A following valid start clears invalid to 0.
- start held high for the entire operation, with a/b changed mid-CALC → only one operation runs, using the operands latched at the start edge. done pulses once; the next start is accepted in IDLE.
- Assert rst two cycles into CALC → immediately busy=0, done=0, sum=0, cout=0. No done pulse. After release, a fresh start gives the correct result.
